pipelined_control_stage: RTL and testbench

Registered successor to the combinational MIPS control decoder. It decodes the ID-stage instruction, detects load-use hazards, and produces a registered ID/EX control bundle: bubbles on stall, cleared on branch flush. With multiply/divide support compiled in, it also tracks a parametrised-latency mult/div unit and stalls HI/LO reads until the result is ready. It sits between the IF/ID register and the EX stage of the five-stage pipeline and drives the PC/IF-ID write-enable.

---
 rtl/pipelined_control_stage_if.sv | 42 ++++
 rtl/pipelined_control_stage.sv | 208 ++++++++++++++++++++
 tb/tb_pipelined_control_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_stage_if.sv
// ID/EX control bus for pipelined_control_stage.
// The master side drives the ID-stage instruction and the EX-stage load info.
// The slave side (the control stage) returns the stall and the registered EX bundle.
interface pipelined_control_stage_if #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALUCTL_W = 4
);
  logic [31:0]         instr;
  logic                instr_valid;
  logic                flush;
  logic                ex_mem_read;
  logic [REG_AW-1:0]   ex_rt;
  logic                stall;
  logic                ex_valid;
  logic                ex_MemtoReg;
  logic                ex_RegWrite;
  logic                ex_MemWrite;
  logic                ex_MemRead;
  logic                ex_ALUSrc;
  logic                ex_RegDst;
  logic                ex_Jump;
  logic                ex_ZeroExt;
  logic [1:0]          ex_Branch;
  logic [ALUCTL_W-1:0] ex_ALUControl;
  logic                ex_illegal;
  logic [1:0]          ex_md_op;
  logic [1:0]          ex_md_rd;

  modport master (
    output instr, instr_valid, flush, ex_mem_read, ex_rt,
    input  stall, ex_valid, ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_MemRead,
           ex_ALUSrc, ex_RegDst, ex_Jump, ex_ZeroExt, ex_Branch, ex_ALUControl,
           ex_illegal, ex_md_op, ex_md_rd
  );

  modport slave (
    input  instr, instr_valid, flush, ex_mem_read, ex_rt,
    output stall, ex_valid, ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_MemRead,
           ex_ALUSrc, ex_RegDst, ex_Jump, ex_ZeroExt, ex_Branch, ex_ALUControl,
           ex_illegal, ex_md_op, ex_md_rd
  );
endinterface

// File: rtl/pipelined_control_stage.sv
// pipelined_control_stage: MIPS ID-stage decoder with load-use hazard detection
// and a registered ID/EX control bundle (bubble on stall, cleared on flush).
// Optional multiply/divide tracking is compiled in with PIPELINED_CONTROL_MULDIV_EN.
module pipelined_control_stage #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned ALUCTL_W   = 4,
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pipelined_control_stage_if.slave bus
);

  localparam logic [ALUCTL_W-1:0] ALU_AND  = ALUCTL_W'(4'b0000);
  localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(4'b0001);
  localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(4'b0010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(4'b0110);
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(4'b0111);
  localparam logic [ALUCTL_W-1:0] ALU_NOR  = ALUCTL_W'(4'b1100);
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = ALUCTL_W'(4'b1101);
  localparam logic [ALUCTL_W-1:0] ALU_NONE = ALUCTL_W'(4'b1111);

  typedef struct packed {
    logic                valid;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_write;
    logic                mem_read;
    logic                alu_src;
    logic                reg_dst;
    logic                jump;
    logic                zero_ext;
    logic [1:0]          branch;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                illegal;
    logic [1:0]          md_op;
    logic [1:0]          md_rd;
  } ctrl_t;

  function automatic ctrl_t bubble_ctrl();
    ctrl_t c;
    c         = '0;
    c.alu_ctl = ALU_NONE;
    return c;
  endfunction

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              rt_src;
  logic              hazard;
  logic              md_stall;
  logic              stall_int;
  ctrl_t             dec;
  ctrl_t             ex;
  logic              unused_fields;

  assign op            = bus.instr[31:26];
  assign funct         = bus.instr[5:0];
  assign rs            = REG_AW'(bus.instr[25:21]);
  assign rt            = REG_AW'(bus.instr[20:16]);
  assign unused_fields = ^bus.instr[15:6];

  // Combinational decode of the ID-stage instruction; invalid slots decode as a bubble.
  always_comb begin
    dec    = bubble_ctrl();
    rt_src = 1'b0;
    if (bus.instr_valid) begin
      dec.valid = 1'b1;
      case (op)
        6'h00: begin
          rt_src        = 1'b1;
          dec.reg_write = 1'b1;
          case (funct)
            6'h20, 6'h21: dec.alu_ctl = ALU_ADD;
            6'h22, 6'h23: dec.alu_ctl = ALU_SUB;
            6'h24:        dec.alu_ctl = ALU_AND;
            6'h25:        dec.alu_ctl = ALU_OR;
            6'h26:        dec.alu_ctl = ALU_XOR;
            6'h27:        dec.alu_ctl = ALU_NOR;
            6'h2a:        dec.alu_ctl = ALU_SLT;
`ifdef PIPELINED_CONTROL_MULDIV_EN
            6'h18, 6'h19: begin
              dec.reg_write = 1'b0;
              dec.md_op     = 2'b01;
            end
            6'h1a, 6'h1b: begin
              dec.reg_write = 1'b0;
              dec.md_op     = 2'b10;
            end
            6'h10:        dec.md_rd = 2'b01;
            6'h12:        dec.md_rd = 2'b10;
`endif
            default: begin
              dec.reg_write = 1'b0;
              dec.illegal   = 1'b1;
            end
          endcase
        end
        6'h04: begin
          rt_src      = 1'b1;
          dec.branch  = 2'b01;
          dec.alu_ctl = ALU_SUB;
        end
        6'h05: begin
          rt_src      = 1'b1;
          dec.branch  = 2'b10;
          dec.alu_ctl = ALU_SUB;
        end
        6'h23: begin
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_dst    = 1'b1;
          dec.alu_ctl    = ALU_ADD;
        end
        6'h2b: begin
          rt_src        = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_ctl   = ALU_ADD;
        end
        6'h08, 6'h09: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_dst   = 1'b1;
          dec.alu_ctl   = ALU_ADD;
        end
        6'h0c, 6'h0d, 6'h0e: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_dst   = 1'b1;
          dec.zero_ext  = 1'b1;
          dec.alu_ctl   = (op == 6'h0c) ? ALU_AND : (op == 6'h0d) ? ALU_OR : ALU_XOR;
        end
        6'h02: dec.jump = 1'b1;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Load-use hazard: EX load writes a register this instruction reads.
  always_comb begin
    hazard = bus.ex_mem_read && (bus.ex_rt != '0) &&
             ((bus.ex_rt == rs) || (rt_src && (bus.ex_rt == rt)));
  end

`ifdef PIPELINED_CONTROL_MULDIV_EN
  logic [3:0] md_cnt;
  logic       md_issue;

  assign md_issue = !bus.flush && !stall_int && (dec.md_op != 2'b00);

  // An mfhi/mflo may leave ID once the counter will have reached zero by the
  // time it sits in EX, hence the compare against 1 rather than 0.
  always_comb begin
    md_stall = (dec.md_rd != 2'b00) && (md_cnt > 4'd1);
  end

  // Busy counter: reload on every mult/div that actually enters EX, else count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_issue) begin
      md_cnt <= 4'(MD_LATENCY);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end
`else
  always_comb begin
    md_stall = 1'b0;
  end
`endif

  // Stall request, suppressed during reset, on empty slots, and by a taken flush.
  always_comb begin
    stall_int = !reset && bus.instr_valid && !bus.flush && (hazard || md_stall);
  end

  // ID/EX register: reset, flush and stall all insert a bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || stall_int) begin
      ex <= bubble_ctrl();
    end else begin
      ex <= dec;
    end
  end

  assign bus.stall         = stall_int;
  assign bus.ex_valid      = ex.valid;
  assign bus.ex_MemtoReg   = ex.mem_to_reg;
  assign bus.ex_RegWrite   = ex.reg_write;
  assign bus.ex_MemWrite   = ex.mem_write;
  assign bus.ex_MemRead    = ex.mem_read;
  assign bus.ex_ALUSrc     = ex.alu_src;
  assign bus.ex_RegDst     = ex.reg_dst;
  assign bus.ex_Jump       = ex.jump;
  assign bus.ex_ZeroExt    = ex.zero_ext;
  assign bus.ex_Branch     = ex.branch;
  assign bus.ex_ALUControl = ex.alu_ctl;
  assign bus.ex_illegal    = ex.illegal;
  assign bus.ex_md_op      = ex.md_op;
  assign bus.ex_md_rd      = ex.md_rd;

endmodule

// File: tb/tb_pipelined_control_stage.sv
// Directed bench for pipelined_control_stage. The EX bundle is compared as one
// 20-bit vector ordered: valid,MemtoReg,RegWrite,MemWrite,MemRead,ALUSrc,
// RegDst,Jump,ZeroExt,Branch[1:0],ALUControl[3:0],illegal,md_op[1:0],md_rd[1:0].
module tb_pipelined_control_stage;
  logic clk = 1'b0;
  logic reset;
  int unsigned total  = 0;
  int unsigned passed = 0;

  pipelined_control_stage_if #(.REG_AW(5), .ALUCTL_W(4)) bus ();

  pipelined_control_stage #(.REG_AW(5), .ALUCTL_W(4), .MD_LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [19:0] ctrl;
  assign ctrl = {bus.ex_valid, bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemWrite,
                 bus.ex_MemRead, bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_Jump,
                 bus.ex_ZeroExt, bus.ex_Branch, bus.ex_ALUControl, bus.ex_illegal,
                 bus.ex_md_op, bus.ex_md_rd};

  localparam logic [19:0] BUBBLE = 20'b0_0_0_0_0_0_0_0_0_00_1111_0_00_00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic f,
                       input logic mr, input logic [4:0] r);
    bus.instr       = i;
    bus.instr_valid = v;
    bus.flush       = f;
    bus.ex_mem_read = mr;
    bus.ex_rt       = r;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0043_1020, 1'b1, 1'b0, 1'b1, 5'd2);
    step();
    step();
    chk("reset_bundle", 32'(ctrl), 32'(BUBBLE));
    chk("reset_stall", 32'(bus.stall), 32'd0);

    // Release with sll (unsupported).
    reset = 1'b0;
    drive(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("sll_stall", 32'(bus.stall), 32'd0);
    step();
    chk("sll_illegal", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_00_1111_1_00_00));

    // lw $2,4($1)
    drive(32'h8C22_0004, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("lw", 32'(ctrl), 32'(20'b1_1_1_0_1_1_1_0_0_00_0010_0_00_00));

    // add $2,$2,$3 behind the load: one stall cycle, bubble, then the add.
    drive(32'h0043_1020, 1'b1, 1'b0, 1'b1, 5'd2);
    chk("loaduse_stall", 32'(bus.stall), 32'd1);
    step();
    chk("loaduse_bubble", 32'(ctrl), 32'(BUBBLE));
    drive(32'h0043_1020, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("loaduse_release", 32'(bus.stall), 32'd0);
    step();
    chk("add", 32'(ctrl), 32'(20'b1_0_1_0_0_0_0_0_0_00_0010_0_00_00));

    // Load into $0 never stalls.
    drive(32'h0003_1020, 1'b1, 1'b0, 1'b1, 5'd0);
    chk("rt0_nostall", 32'(bus.stall), 32'd0);
    // rt of lw / ori is a destination, not a source.
    drive(32'h8C22_0004, 1'b1, 1'b0, 1'b1, 5'd2);
    chk("lw_rt_nosrc", 32'(bus.stall), 32'd0);
    drive(32'h3422_FFFF, 1'b1, 1'b0, 1'b1, 5'd2);
    chk("ori_rt_nosrc", 32'(bus.stall), 32'd0);
    drive(32'h3422_FFFF, 1'b1, 1'b0, 1'b1, 5'd1);
    chk("ori_rs_hazard", 32'(bus.stall), 32'd1);
    // Empty slot never stalls.
    drive(32'h0043_1020, 1'b0, 1'b0, 1'b1, 5'd2);
    chk("invalid_nostall", 32'(bus.stall), 32'd0);
    step();
    chk("invalid_bubble", 32'(ctrl), 32'(BUBBLE));

    // beq with rt hazard, then with flush.
    drive(32'h1022_0003, 1'b1, 1'b0, 1'b1, 5'd2);
    chk("beq_hazard", 32'(bus.stall), 32'd1);
    drive(32'h1022_0003, 1'b1, 1'b1, 1'b1, 5'd2);
    chk("flush_nostall", 32'(bus.stall), 32'd0);
    step();
    chk("flush_bubble", 32'(ctrl), 32'(BUBBLE));

    // Remaining opcode and funct coverage.
    drive(32'h3422_FFFF, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("ori", 32'(ctrl), 32'(20'b1_0_1_0_0_1_1_0_1_00_0001_0_00_00));
    drive(32'hAC22_0004, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("sw", 32'(ctrl), 32'(20'b1_0_0_1_0_1_0_0_0_00_0010_0_00_00));
    drive(32'h1422_0003, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("bne", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_10_0110_0_00_00));
    drive(32'h0800_0010, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("j", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_1_0_00_1111_0_00_00));
    drive(32'h2022_0005, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("addi", 32'(ctrl), 32'(20'b1_0_1_0_0_1_1_0_0_00_0010_0_00_00));
    drive(32'h3022_00FF, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("andi", 32'(ctrl), 32'(20'b1_0_1_0_0_1_1_0_1_00_0000_0_00_00));
    drive(32'h0043_1022, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("sub", 32'(ctrl), 32'(20'b1_0_1_0_0_0_0_0_0_00_0110_0_00_00));
    drive(32'h0043_1026, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("xor", 32'(ctrl), 32'(20'b1_0_1_0_0_0_0_0_0_00_1101_0_00_00));
    drive(32'h0043_1027, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("nor", 32'(ctrl), 32'(20'b1_0_1_0_0_0_0_0_0_00_1100_0_00_00));
    drive(32'h0043_102A, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("slt", 32'(ctrl), 32'(20'b1_0_1_0_0_0_0_0_0_00_0111_0_00_00));
    drive(32'hFC00_0000, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("bad_opcode", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_00_1111_1_00_00));

`ifdef PIPELINED_CONTROL_MULDIV_EN
    // mult then mflo: three stall cycles, mflo registered on the fourth.
    drive(32'h0043_0018, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("mult", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_00_1111_0_01_00));
    drive(32'h0000_1012, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("md_stall1", 32'(bus.stall), 32'd1);
    step();
    chk("md_bubble", 32'(ctrl), 32'(BUBBLE));
    chk("md_stall2", 32'(bus.stall), 32'd1);
    step();
    chk("md_stall3", 32'(bus.stall), 32'd1);
    step();
    chk("md_ready", 32'(bus.stall), 32'd0);
    step();
    chk("mflo", 32'(ctrl), 32'(20'b1_0_1_0_0_0_0_0_0_00_1111_0_00_10));
    // Reset mid-busy clears the counter.
    drive(32'h0043_001A, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("div", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_00_1111_0_10_00));
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(32'h0000_1010, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("md_reset_clear", 32'(bus.stall), 32'd0);
    // A flushed mult does not start the counter.
    drive(32'h0043_0018, 1'b1, 1'b1, 1'b0, 5'd0);
    step();
    drive(32'h0000_1010, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("md_flush_noload", 32'(bus.stall), 32'd0);
`else
    // Without mult/div support those functs are illegal and never stall.
    drive(32'h0043_0018, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("mult_illegal", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_00_1111_1_00_00));
    drive(32'h0000_1012, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("mflo_nostall", 32'(bus.stall), 32'd0);
    step();
    chk("mflo_illegal", 32'(ctrl), 32'(20'b1_0_0_0_0_0_0_0_0_00_1111_1_00_00));
`endif

    // Reset while a hazard is pending.
    drive(32'h0043_1020, 1'b1, 1'b0, 1'b1, 5'd2);
    reset = 1'b1;
    #1;
    chk("reset_kills_stall", 32'(bus.stall), 32'd0);
    step();
    chk("reset_again_bundle", 32'(ctrl), 32'(BUBBLE));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
